// File: rtl/dac_spi_pkg.sv
// Shared constants and state types for the DAC SPI sequencer.
package dac_spi_pkg;

   // SPI core register map
   localparam logic [2:0] ADDR_TXDATA  = 3'd1;
   localparam logic [2:0] ADDR_STATUS  = 3'd2;
   localparam logic [2:0] ADDR_CONTROL = 3'd3;

   // Register bit positions
   localparam int STATUS_TMT_BIT = 5;
   localparam int CTRL_SSO_BIT   = 10;

   localparam logic [15:0] STATUS_TMT_MASK = 16'h0001 << STATUS_TMT_BIT;
   localparam logic [15:0] CTRL_SSO_WORD   = 16'h0001 << CTRL_SSO_BIT;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_SSO_ON,
      ST_WAIT_HI,
      ST_WR_HI,
      ST_WAIT_LO,
      ST_WR_LO,
      ST_POLL,
      ST_SSO_OFF,
      ST_CLR,
      ST_DONE
   } seq_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_A,
      PH_B,
      PH_C
   } bus_phase_e;

endpackage

// File: rtl/dac_spi_sequencer_regbus.sv
// Three-cycle register access engine for the SPI core control port.
// Cycles A/B drive select and one strobe, cycle C is the idle gap in which
// read data is sampled; ack pulses on the cycle after the gap.
module spi_regbus_access
   import dac_spi_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req,
   input  logic        rd,
   input  logic [2:0]  addr,
   input  logic [15:0] wdata,
   output logic        ack,
   output logic [15:0] rdata,
   output logic        spi_select,
   output logic        spi_write_n,
   output logic        spi_read_n,
   output logic [2:0]  spi_addr,
   output logic [15:0] spi_wdata,
   input  logic [15:0] spi_rdata
);

   bus_phase_e phase;

   // Phase sequencer and registered bus outputs; a new access is refused
   // while ack is high so a held request is not replayed.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase       <= PH_IDLE;
         ack         <= 1'b0;
         spi_select  <= 1'b0;
         spi_write_n <= 1'b1;
         spi_read_n  <= 1'b1;
         spi_addr    <= 3'd0;
         spi_wdata   <= 16'd0;
      end else begin
         ack <= 1'b0;
         case (phase)
            PH_IDLE: begin
               if (req && !ack) begin
                  phase       <= PH_A;
                  spi_select  <= 1'b1;
                  spi_write_n <= rd;
                  spi_read_n  <= !rd;
                  spi_addr    <= addr;
                  spi_wdata   <= wdata;
               end
            end
            PH_A: phase <= PH_B;
            PH_B: begin
               phase       <= PH_C;
               spi_select  <= 1'b0;
               spi_write_n <= 1'b1;
               spi_read_n  <= 1'b1;
            end
            PH_C: begin
               phase <= PH_IDLE;
               ack   <= 1'b1;
            end
            default: phase <= PH_IDLE;
         endcase
      end
   end

   // Capture read data during the gap cycle.
   always_ff @(posedge clk) begin
      if (phase == PH_C) rdata <= spi_rdata;
   end

endmodule

// File: rtl/dac_spi_sequencer.sv
// Sends a 16-bit DAC code to the SPI core as one two-byte frame (MSB first)
// with chip-select held via SSO, then clears the status flags.
module dac_spi_sequencer
   import dac_spi_pkg::*;
#(
   parameter logic [15:0] INIT_VALUE    = 16'h7FFF,
   parameter bit          INIT_ON_RESET = 1'b1
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic [15:0] dac_val,
   input  logic        dac_load,
   output logic        busy,
   output logic        done,
   output logic        spi_select,
   output logic        spi_write_n,
   output logic        spi_read_n,
   output logic [2:0]  spi_addr,
   output logic [15:0] spi_wdata,
   input  logic [15:0] spi_rdata,
   input  logic        spi_readyfordata
);

   seq_state_e  state, state_nxt;
   logic        init_q;
   logic        pend_q;
   logic        lo_armed;
   logic [15:0] code;
   logic [15:0] pend_val;
   logic        load_to_pend;

   logic        bus_req;
   logic        bus_rd;
   logic [2:0]  bus_addr;
   logic [15:0] bus_wdata;
   logic        bus_ack;
   logic [15:0] bus_rdata;
   logic        tmt_set;

   assign tmt_set = |(bus_rdata & STATUS_TMT_MASK);
   assign busy    = (state != ST_IDLE);
   assign done    = (state == ST_DONE);

   // A load goes to the pending slot whenever it cannot start a frame now;
   // loads in DONE are picked up directly by the next frame.
   assign load_to_pend = dac_load &&
                         ((state == ST_IDLE && init_q) ||
                          (state != ST_IDLE && state != ST_DONE));

   spi_regbus_access u_bus (
      .clk         (clk),
      .reset_n     (reset_n),
      .req         (bus_req),
      .rd          (bus_rd),
      .addr        (bus_addr),
      .wdata       (bus_wdata),
      .ack         (bus_ack),
      .rdata       (bus_rdata),
      .spi_select  (spi_select),
      .spi_write_n (spi_write_n),
      .spi_read_n  (spi_read_n),
      .spi_addr    (spi_addr),
      .spi_wdata   (spi_wdata),
      .spi_rdata   (spi_rdata)
   );

   // State register plus init/pending flags and the WAIT_LO first-cycle mask.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_IDLE;
         init_q   <= INIT_ON_RESET;
         pend_q   <= 1'b0;
         lo_armed <= 1'b0;
      end else begin
         state    <= state_nxt;
         lo_armed <= (state == ST_WAIT_LO);
         if (state == ST_IDLE) init_q <= 1'b0;
         if (state == ST_DONE)  pend_q <= 1'b0;
         else if (load_to_pend) pend_q <= 1'b1;
      end
   end

   // Code registers; newest load wins for the pending slot.
   always_ff @(posedge clk) begin
      if (load_to_pend) pend_val <= dac_val;
      if (state == ST_IDLE)      code <= init_q ? INIT_VALUE : dac_val;
      else if (state == ST_DONE) code <= dac_load ? dac_val : pend_val;
   end

   // Next-state and bus request decode.
   always_comb begin
      state_nxt = state;
      bus_req   = 1'b0;
      bus_rd    = 1'b0;
      bus_addr  = ADDR_CONTROL;
      bus_wdata = 16'd0;
      case (state)
         ST_IDLE: begin
            if (init_q || dac_load) state_nxt = ST_SSO_ON;
         end
         ST_SSO_ON: begin
            bus_req   = 1'b1;
            bus_addr  = ADDR_CONTROL;
            bus_wdata = CTRL_SSO_WORD;
            if (bus_ack) state_nxt = ST_WAIT_HI;
         end
         ST_WAIT_HI: begin
            if (spi_readyfordata) state_nxt = ST_WR_HI;
         end
         ST_WR_HI: begin
            bus_req   = 1'b1;
            bus_addr  = ADDR_TXDATA;
            bus_wdata = {8'h00, code[15:8]};
            if (bus_ack) state_nxt = ST_WAIT_LO;
         end
         ST_WAIT_LO: begin
            if (lo_armed && spi_readyfordata) state_nxt = ST_WR_LO;
         end
         ST_WR_LO: begin
            bus_req   = 1'b1;
            bus_addr  = ADDR_TXDATA;
            bus_wdata = {8'h00, code[7:0]};
            if (bus_ack) state_nxt = ST_POLL;
         end
         ST_POLL: begin
            bus_req  = 1'b1;
            bus_rd   = 1'b1;
            bus_addr = ADDR_STATUS;
            if (bus_ack && tmt_set) state_nxt = ST_SSO_OFF;
         end
         ST_SSO_OFF: begin
            bus_req  = 1'b1;
            bus_addr = ADDR_CONTROL;
            if (bus_ack) state_nxt = ST_CLR;
         end
         ST_CLR: begin
            bus_req  = 1'b1;
            bus_addr = ADDR_STATUS;
            if (bus_ack) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            state_nxt = (pend_q || dac_load) ? ST_SSO_ON : ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule
